// File: rtl/duty_capture.sv
// rtl/duty_capture.sv - PWM / sigma-delta duty recovery over a fixed sample window
//
// Samples a single-bit drive line on a programmable tick and counts the high
// samples over 2^WINDOW_LOG2 ticks. At the end of each window it publishes an
// 8-bit duty value with a one-cycle valid strobe.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_speed      sample-tick divider, one tick every i_speed+1 clocks
//   i_enable     measurement enable; low holds the window machinery at zero
//   i_pwm        line under measurement, may be asynchronous to i_clk
//   o_duty       last measured duty, 0..255
//   o_valid      one-cycle pulse when o_duty and the flags update
//   o_stuck_high last window had every sample high
//   o_stuck_low  last window had every sample low
module duty_capture #(
  parameter int WINDOW_LOG2 = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [19:0] i_speed,
  input  logic        i_enable,
  input  logic        i_pwm,
  output logic [7:0]  o_duty,
  output logic        o_valid,
  output logic        o_stuck_high,
  output logic        o_stuck_low
);

  localparam int N     = WINDOW_LOG2;
  localparam int SHIFT = WINDOW_LOG2 - 8;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_pwm;
  logic [19:0]            div;
  logic                   tick;
  logic [N-1:0]           scnt;
  logic [N:0]             acc;
  logic [N:0]             total;
  logic [8:0]             shifted;
  logic [7:0]             duty_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pwm};
    end
  end

  assign s_pwm = sync_q[SYNC_STAGES-1];

  // Using >= lets a lowered i_speed take effect on the next clock instead of
  // letting div run on through the 20-bit wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      div <= '0;
    end else if (div >= i_speed) begin
      div <= '0;
    end else begin
      div <= div + 20'd1;
    end
  end

  assign tick = (div == 20'd0) && i_enable;

  // total can reach exactly 2^N (every sample high); that single value lands
  // in bit 8 after the shift and saturates to 255.
  assign total     = acc + {{N{1'b0}}, s_pwm};
  assign shifted   = 9'(total >> SHIFT);
  assign duty_next = shifted[8] ? 8'hff : shifted[7:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scnt         <= '0;
      acc          <= '0;
      o_duty       <= '0;
      o_valid      <= 1'b0;
      o_stuck_high <= 1'b0;
      o_stuck_low  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!i_enable) begin
        // A dropped enable throws away the partial window; the next rise
        // starts counting from zero.
        scnt <= '0;
        acc  <= '0;
      end else if (tick) begin
        if (scnt == {N{1'b1}}) begin
          o_duty       <= duty_next;
          o_stuck_high <= total[N];
          o_stuck_low  <= (total == '0);
          o_valid      <= 1'b1;
          scnt         <= '0;
          acc          <= '0;
        end else begin
          scnt <= scnt + 1'b1;
          acc  <= total;
        end
      end
    end
  end

endmodule
